// File: rtl/kathryn_phase_seq.sv
// Multi-phase accumulator sequencer: up to NPHASE programmed {op, operand, limit}
// slots run back to back on an 8-bit accumulator, one op per clock.
module kathryn_phase_seq #(
    parameter int DATA_W    = 8,
    parameter int NPHASE    = 4,
    parameter int MAX_STEPS = 255,
    localparam int IDX_W    = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [1:0]        cfg_op,
    input  logic [DATA_W-1:0] cfg_arg,
    input  logic [DATA_W-1:0] cfg_lim,
    input  logic [IDX_W-1:0]  last_phase,
    input  logic [DATA_W-1:0] init_val,
    input  logic              start,
    input  logic              abort,
    output logic [DATA_W-1:0] a,
    output logic [IDX_W-1:0]  b,
    output logic [7:0]        c,
    output logic [3:0]        d
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    logic [1:0]        state_reg, state_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [IDX_W-1:0]  b_reg, b_next;
    logic [7:0]        c_reg, c_next;
    logic              err_reg, err_next;
    logic [IDX_W-1:0]  last_reg, last_next;
    logic              cfg_rej_reg;

    logic [1:0]        op_arr  [NPHASE];
    logic [DATA_W-1:0] arg_arr [NPHASE];
    logic [DATA_W-1:0] lim_arr [NPHASE];

    logic busy;
    logic done;

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);

    // Slot registers are cleared by reset, so they live in flops rather than RAM.
    generate
        for (genvar gi = 0; gi < NPHASE; gi++) begin : g_slot
            logic [1:0]        op_reg;
            logic [DATA_W-1:0] arg_reg;
            logic [DATA_W-1:0] lim_reg;
            logic              slot_we;

            assign slot_we = cfg_we && !busy && (cfg_idx == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    op_reg  <= OP_ADD;
                    arg_reg <= '0;
                    lim_reg <= '0;
                end else if (slot_we) begin
                    op_reg  <= cfg_op;
                    arg_reg <= cfg_arg;
                    lim_reg <= cfg_lim;
                end
            end

            assign op_arr[gi]  = op_reg;
            assign arg_arr[gi] = arg_reg;
            assign lim_arr[gi] = lim_reg;
        end
    endgenerate

    function automatic logic [DATA_W-1:0] apply_op(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] arg
    );
        logic [DATA_W-1:0] res;
        res = acc;
        case (op)
            OP_ADD:  res = acc + arg;
            OP_SUB:  res = acc - arg;
            OP_SHL:  res = acc << arg[2:0];
            OP_HOLD: res = acc;
            default: res = acc;
        endcase
        return res;
    endfunction

    logic [IDX_W-1:0]  b_inc;
    logic [DATA_W-1:0] cur_res;
    logic [DATA_W-1:0] nxt_res;
    logic              at_limit;

    assign b_inc    = b_reg + IDX_W'(1);
    assign at_limit = (a_reg == lim_arr[b_reg]);
    assign cur_res  = apply_op(op_arr[b_reg], a_reg, arg_arr[b_reg]);
    // Phase change applies the next slot's op on the same edge, so no bubble.
    assign nxt_res  = apply_op(op_arr[b_inc], a_reg, arg_arr[b_inc]);

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        c_next     = c_reg;
        err_next   = err_reg;
        last_next  = last_reg;

        if (abort) begin
            if (state_reg != ST_IDLE) begin
                state_next = ST_IDLE;
                err_next   = 1'b0;
            end
        end else if (start && (state_reg != ST_RUN)) begin
            state_next = ST_RUN;
            a_next     = init_val;
            b_next     = '0;
            c_next     = '0;
            err_next   = 1'b0;
            last_next  = last_phase;
        end else if (state_reg == ST_RUN) begin
            if (!at_limit) begin
                if (c_reg == 8'(MAX_STEPS)) begin
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    a_next = cur_res;
                    c_next = c_reg + 8'd1;
                end
            end else if (b_reg < last_reg) begin
                a_next = nxt_res;
                b_next = b_inc;
                c_next = '0;
            end else begin
                state_next = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            c_reg       <= '0;
            err_reg     <= 1'b0;
            last_reg    <= '0;
            cfg_rej_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            c_reg       <= c_next;
            err_reg     <= err_next;
            last_reg    <= last_next;
            cfg_rej_reg <= cfg_we && busy;
        end
    end

    assign a = a_reg;
    assign b = b_reg;
    assign c = c_reg;
    assign d = {err_reg, done, busy, cfg_rej_reg};

endmodule

// File: tb/tb_kathryn_phase_seq.sv
// Directed bench for kathryn_phase_seq: table-driven main sequence plus
// hand-written wrap, guard, abort, config-reject and reset sequences.
module tb_kathryn_phase_seq;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [1:0] cfg_op;
    logic [7:0] cfg_arg;
    logic [7:0] cfg_lim;
    logic [1:0] last_phase;
    logic [7:0] init_val;
    logic       start;
    logic       abort;
    logic [7:0] a;
    logic [1:0] b;
    logic [7:0] c;
    logic [3:0] d;

    int checks   = 0;
    int failures = 0;

    kathryn_phase_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_op     (cfg_op),
        .cfg_arg    (cfg_arg),
        .cfg_lim    (cfg_lim),
        .last_phase (last_phase),
        .init_val   (init_val),
        .start      (start),
        .abort      (abort),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [7:0] ea;
        logic [1:0] eb;
        logic [7:0] ec;
        logic [3:0] ed;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [1:0] op,
                             input logic [7:0] arg, input logic [7:0] lim);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_op  = op;
        cfg_arg = arg;
        cfg_lim = lim;
        @(negedge clk);
        cfg_we  = 1'b0;
        $display("cfg slot=%0d op=%0d arg=%0d lim=%0d", idx, op, arg, lim);
    endtask

    task automatic program_t1();
        cfg_write(2'd0, 2'b00, 8'd1, 8'd8);
        cfg_write(2'd1, 2'b00, 8'd2, 8'd16);
        cfg_write(2'd2, 2'b00, 8'd8, 8'd24);
        cfg_write(2'd3, 2'b10, 8'd1, 8'd48);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 16; i++) begin
            init_val   = 8'd2;
            last_phase = 2'd3;
            start      = vecs[i].start;
            @(negedge clk);
            start = 1'b0;
            $display("%s vec=%0d a=%0d b=%0d c=%0d d=%b", tag, i, a, b, c, d);
            chk({tag, "_a"}, int'(a), int'(vecs[i].ea));
            chk({tag, "_b"}, int'(b), int'(vecs[i].eb));
            chk({tag, "_c"}, int'(c), int'(vecs[i].ec));
            chk({tag, "_d"}, int'(d), int'(vecs[i].ed));
        end
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (d[2] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (d[2] !== 1'b1) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int   n;
        logic [7:0] exp_a;

        // Test 1 expectation: start edge, 12 ops, DONE, hold.
        vecs[0]  = '{1'b1, 8'd2,  2'd0, 8'd0, 4'b0010};
        vecs[1]  = '{1'b0, 8'd3,  2'd0, 8'd1, 4'b0010};
        vecs[2]  = '{1'b0, 8'd4,  2'd0, 8'd2, 4'b0010};
        vecs[3]  = '{1'b0, 8'd5,  2'd0, 8'd3, 4'b0010};
        vecs[4]  = '{1'b0, 8'd6,  2'd0, 8'd4, 4'b0010};
        vecs[5]  = '{1'b0, 8'd7,  2'd0, 8'd5, 4'b0010};
        vecs[6]  = '{1'b0, 8'd8,  2'd0, 8'd6, 4'b0010};
        vecs[7]  = '{1'b0, 8'd10, 2'd1, 8'd0, 4'b0010};
        vecs[8]  = '{1'b0, 8'd12, 2'd1, 8'd1, 4'b0010};
        vecs[9]  = '{1'b0, 8'd14, 2'd1, 8'd2, 4'b0010};
        vecs[10] = '{1'b0, 8'd16, 2'd1, 8'd3, 4'b0010};
        vecs[11] = '{1'b0, 8'd24, 2'd2, 8'd0, 4'b0010};
        vecs[12] = '{1'b0, 8'd48, 2'd3, 8'd0, 4'b0010};
        vecs[13] = '{1'b0, 8'd48, 2'd3, 8'd0, 4'b0100};
        vecs[14] = '{1'b0, 8'd48, 2'd3, 8'd0, 4'b0100};
        vecs[15] = '{1'b0, 8'd48, 2'd3, 8'd0, 4'b0100};

        rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_op = '0; cfg_arg = '0;
        cfg_lim = '0; last_phase = '0; init_val = '0; start = 1'b0; abort = 1'b0;
        #12;
        chk("reset_a", int'(a), 0);
        chk("reset_b", int'(b), 0);
        chk("reset_c", int'(c), 0);
        chk("reset_d", int'(d), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Test 1: four phases with in-edge phase advance
        program_t1();
        run_table("t1");

        // Test 2: modulo wrap inside a single phase
        cfg_write(2'd0, 2'b00, 8'd1, 8'd3);
        init_val = 8'd250; last_phase = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_a = 8'd250;
        chk("t2_start_a", int'(a), int'(exp_a));
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            exp_a = exp_a + 8'd1;
            chk("t2_a", int'(a), int'(exp_a));
        end
        @(negedge clk);
        $display("t2 done a=%0d c=%0d d=%b", a, c, d);
        chk("t2_done_a", int'(a), 3);
        chk("t2_done_c", int'(c), 9);
        chk("t2_done_d", int'(d), 4'b0100);

        // Test 3: step guard, limit never reached by even steps
        cfg_write(2'd0, 2'b00, 8'd2, 8'd7);
        init_val = 8'd0; last_phase = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t3", 400, n);
        $display("t3 guard n=%0d a=%0d c=%0d d=%b", n, a, c, d);
        chk("t3_edges", n, 256);
        chk("t3_a", int'(a), 254);
        chk("t3_c", int'(c), 255);
        chk("t3_d", int'(d), 4'b1100);
        @(negedge clk);
        chk("t3_hold_a", int'(a), 254);

        // Test 4: abort at a=5 (start asserted too; abort wins), then restart
        program_t1();
        init_val = 8'd2; last_phase = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_pre_a", int'(a), 5);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        $display("t4 abort a=%0d b=%0d c=%0d d=%b", a, b, c, d);
        chk("t4_abort_a", int'(a), 5);
        chk("t4_abort_c", int'(c), 3);
        chk("t4_abort_d", int'(d), 4'b0000);
        @(negedge clk);
        chk("t4_idle_a", int'(a), 5);
        run_table("t4");

        // Test 5: config write and start while busy are both rejected
        init_val = 8'd2; last_phase = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_op = 2'b01; cfg_arg = 8'd5; cfg_lim = 8'd99;
        start = 1'b1; init_val = 8'd100;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0; init_val = 8'd2;
        $display("t5 rej a=%0d c=%0d d=%b", a, c, d);
        chk("t5_rej_a", int'(a), 3);
        chk("t5_rej_c", int'(c), 1);
        chk("t5_rej_d", int'(d), 4'b0011);
        @(negedge clk);
        chk("t5_after_a", int'(a), 4);
        chk("t5_after_d", int'(d), 4'b0010);
        wait_done("t5", 40, n);
        chk("t5_done_a", int'(a), 48);
        run_table("t5");

        // Test 6: asynchronous reset mid-run clears state and slots
        init_val = 8'd2; last_phase = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_pre_a", int'(a), 4);
        #2 rst = 1'b0;
        #1;
        $display("t6 reset a=%0d b=%0d c=%0d d=%b", a, b, c, d);
        chk("t6_rst_a", int'(a), 0);
        chk("t6_rst_b", int'(b), 0);
        chk("t6_rst_c", int'(c), 0);
        chk("t6_rst_d", int'(d), 0);
        @(negedge clk);
        rst = 1'b1;
        init_val = 8'd0; last_phase = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_start_d", int'(d), 4'b0010);
        @(negedge clk);
        $display("t6 done a=%0d c=%0d d=%b", a, c, d);
        chk("t6_done_d", int'(d), 4'b0100);
        chk("t6_done_a", int'(a), 0);
        chk("t6_done_c", int'(c), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
